// File: rtl/tq_pkg.sv
// Shared constants, types and helpers for the transform/quant pipeline.
package tq_pkg;

  localparam int TQ_SHIFT_1 = 7;   // first (vertical) inverse pass
  localparam int TQ_SHIFT_2 = 12;  // second (horizontal) pass, 20 - bit depth 8
  localparam int TQ_OUT_W   = 16;  // reconstructed sample width

  // Which inverse pass a row belongs to; selects the round/shift amount.
  typedef enum logic {
    PASS_VERT = 1'b0,
    PASS_HORZ = 1'b1
  } pass_e;

  // Saturate a signed value to the range of a w-bit signed number.
  function automatic logic signed [31:0] sat_clip(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/ibutterfly1_4_rnd.sv
// Round, arithmetic-shift and clip one butterfly sum to an output sample.
module ibutterfly1_4_rnd
  import tq_pkg::*;
#(
  parameter int IN_W    = 24,
  parameter int OUT_W   = TQ_OUT_W,
  parameter int SHIFT_1 = TQ_SHIFT_1,
  parameter int SHIFT_2 = TQ_SHIFT_2
) (
  input  logic signed [IN_W:0]    sum,
  input  pass_e                   pass,
  output logic signed [OUT_W-1:0] y
);

  // Two bits of headroom over the input so sum + rounding bias never wraps.
  localparam int EXT_W = IN_W + 2;

  int                       sh;
  logic signed [EXT_W-1:0]  ext;
  logic signed [EXT_W-1:0]  bias;
  logic signed [EXT_W-1:0]  biased;
  logic signed [EXT_W-1:0]  shifted;
  logic signed [31:0]       clipped;

  // Add half an LSB of the result, floor-shift, then saturate.
  // NOTE: every variable here is assigned on every path through the block,
  // so the combinational logic never infers a latch.
  always_comb begin
    sh      = (pass == PASS_HORZ) ? SHIFT_2 : SHIFT_1;
    ext     = EXT_W'(sum);
    bias    = EXT_W'(1) <<< (sh - 1);
    biased  = ext + bias;
    shifted = biased >>> sh;
    clipped = sat_clip(32'(shifted), OUT_W);
    y       = OUT_W'(clipped);
  end

endmodule

// File: rtl/ibutterfly1_4.sv
// Final-stage inverse 4-point butterfly: add/sub (S1), round-shift-clip (S2),
// valid/ready handshake and a row counter marking the end of each 4x4 block.
module ibutterfly1_4
  import tq_pkg::*;
#(
  parameter int IN_W    = 24,
  parameter int OUT_W   = TQ_OUT_W,
  parameter int SHIFT_1 = TQ_SHIFT_1,
  parameter int SHIFT_2 = TQ_SHIFT_2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_pass,
  input  logic signed [IN_W-1:0]  i_even_0,
  input  logic signed [IN_W-1:0]  i_even_1,
  input  logic signed [IN_W-1:0]  i_odd_0,
  input  logic signed [IN_W-1:0]  i_odd_1,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic signed [OUT_W-1:0] o_0,
  output logic signed [OUT_W-1:0] o_1,
  output logic signed [OUT_W-1:0] o_2,
  output logic signed [OUT_W-1:0] o_3,
  output logic [1:0]              o_row,
  output logic                    o_last
);

  localparam int SUM_W = IN_W + 1;

  logic                    adv1;
  logic                    adv2;
  logic                    s1_valid;
  pass_e                   s1_pass;
  logic signed [SUM_W-1:0] s1_sum [4];
  logic signed [OUT_W-1:0] rnd_y  [4];

  // A stage may load when its output register is empty or being drained.
  assign adv2    = !o_valid || i_ready;
  assign adv1    = !s1_valid || adv2;
  assign o_ready = adv1;
  assign o_last  = o_valid && (o_row == 2'd3);

  // S1: sign-extend then add/sub; one extra bit makes overflow impossible.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pass  <= PASS_VERT;
      for (int k = 0; k < 4; k++) s1_sum[k] <= '0;
    end else if (adv1) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_pass   <= pass_e'(i_pass);
        s1_sum[0] <= SUM_W'(i_even_0) + SUM_W'(i_odd_0);
        s1_sum[1] <= SUM_W'(i_even_1) + SUM_W'(i_odd_1);
        s1_sum[2] <= SUM_W'(i_even_1) - SUM_W'(i_odd_1);
        s1_sum[3] <= SUM_W'(i_even_0) - SUM_W'(i_odd_0);
      end
    end
  end

  // One round-shift-clip slice per output sample.
  for (genvar k = 0; k < 4; k++) begin : g_rnd
    ibutterfly1_4_rnd #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .SHIFT_1 (SHIFT_1),
      .SHIFT_2 (SHIFT_2)
    ) u_rnd (
      .sum  (s1_sum[k]),
      .pass (s1_pass),
      .y    (rnd_y[k])
    );
  end

  // S2: register the clipped samples; they hold steady while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_0     <= '0;
      o_1     <= '0;
      o_2     <= '0;
      o_3     <= '0;
    end else if (adv2) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_0 <= rnd_y[0];
        o_1 <= rnd_y[1];
        o_2 <= rnd_y[2];
        o_3 <= rnd_y[3];
      end
    end
  end

  // Row index of the presented row; advances on each output transfer, wraps 3 -> 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     o_row <= 2'd0;
    else if (o_valid && i_ready) o_row <= o_row + 2'd1;
  end

endmodule
